// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared types and defaults for the MaxNet sequencing controller
package maxnet_pkg;

  localparam int N_DEF        = 6;
  localparam int UPD_LAT_DEF  = 2;
  localparam int MAX_ITER_DEF = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    LOAD   = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Index width that never collapses to zero bits for tiny ranges.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxnet_onehot_enc.sv
// rtl/maxnet_onehot_enc.sv - classifies the nonzero-flag vector and encodes its lowest set bit
module maxnet_onehot_enc
  import maxnet_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int XW = idx_w(N)
) (
  input  logic [N-1:0]  nz_vec,
  output logic          zero,
  output logic          one,
  output logic          many,
  output logic [XW-1:0] idx
);

  int unsigned cnt;

  always_comb begin
    cnt = 0;
    idx = '0;
    // Scanning downward leaves idx on the lowest set bit.
    for (int i = N - 1; i >= 0; i--) begin
      if (nz_vec[i]) begin
        cnt = cnt + 1;
        idx = XW'(i);
      end
    end
    zero = (cnt == 0);
    one  = (cnt == 1);
    many = (cnt > 1);
  end

endmodule

// File: rtl/maxnet_ctrl.sv
// rtl/maxnet_ctrl.sv - MaxNet load/settle/check sequencer; MAXNET_CTRL_PERF_EN adds a busy-cycle counter
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int UPD_LAT  = UPD_LAT_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int IW       = 7,
  localparam int XW      = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  nz_vec,
  output logic          mem_load,
  output logic          sel_init,
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic          timeout,
  output logic [XW-1:0] winner,
  output logic [IW-1:0] iter_cnt
`ifdef MAXNET_CTRL_PERF_EN
  ,
  output logic [15:0]   cyc_cnt
`endif
);

  localparam int SW = idx_w(UPD_LAT);

  state_e          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            mem_load_q, mem_load_d;
  logic            sel_init_q, sel_init_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic [XW-1:0]   winner_q, winner_d;
  logic [IW-1:0]   iter_q, iter_d;

  logic            nz_zero, nz_one, nz_many;
  logic [XW-1:0]   nz_idx;

  maxnet_onehot_enc #(.N(N)) u_enc (
    .nz_vec (nz_vec),
    .zero   (nz_zero),
    .one    (nz_one),
    .many   (nz_many),
    .idx    (nz_idx)
  );

  // Outputs are computed one state ahead so each lands registered with its state.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    mem_load_d = 1'b0;
    sel_init_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    timeout_d  = timeout_q;
    winner_d   = winner_q;
    iter_d     = iter_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = INIT;
          mem_load_d = 1'b1;
          sel_init_d = 1'b1;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          timeout_d  = 1'b0;
          winner_d   = '0;
          iter_d     = '0;
        end
      end
      INIT, LOAD: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        if (settle_q == SW'(UPD_LAT - 1)) state_d = CHECK;
        else settle_d = settle_q + SW'(1);
      end
      CHECK: begin
        if (nz_one) begin
          state_d  = DONE;
          done_d   = 1'b1;
          valid_d  = 1'b1;
          winner_d = nz_idx;
        end else if (nz_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (nz_many && iter_q == IW'(MAX_ITER)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          state_d    = LOAD;
          mem_load_d = 1'b1;
          iter_d     = (iter_q == IW'(MAX_ITER)) ? iter_q : iter_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      mem_load_q <= 1'b0;
      sel_init_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      winner_q   <= '0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      mem_load_q <= mem_load_d;
      sel_init_q <= sel_init_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      winner_q   <= winner_d;
      iter_q     <= iter_d;
    end
  end

  assign mem_load = mem_load_q;
  assign sel_init = sel_init_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;
  assign winner   = winner_q;
  assign iter_cnt = iter_q;

`ifdef MAXNET_CTRL_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && start) cyc_d = '0;
    else if (busy_q && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_maxnet_ctrl.sv
// tb/tb_maxnet_ctrl.sv - directed self-checking bench for maxnet_ctrl
module tb_maxnet_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] nz_vec = 6'b0;
  logic       mem_load, sel_init, busy, done, valid, timeout;
  logic [2:0] winner;
  logic [6:0] iter_cnt;
`ifdef MAXNET_CTRL_PERF_EN
  logic [15:0] cyc_cnt;
`endif

  maxnet_ctrl #(.N(6), .UPD_LAT(2), .MAX_ITER(4), .IW(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .nz_vec   (nz_vec),
    .mem_load (mem_load),
    .sel_init (sel_init),
    .busy     (busy),
    .done     (done),
    .valid    (valid),
    .timeout  (timeout),
    .winner   (winner),
    .iter_cnt (iter_cnt)
`ifdef MAXNET_CTRL_PERF_EN
    ,
    .cyc_cnt  (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Datapath stand-in: nz_vec after the k-th memory write is seq[k-1], last entry sticks.
  logic [5:0] seq [8];
  int         seq_len;
  int         load_cnt;
  int         done_cnt;
  int         first_sel;
  int         sel_bad;

  always @(negedge clk) begin
    if (mem_load) begin
      load_cnt++;
      if (load_cnt == 1) first_sel = int'(sel_init);
      else if (sel_init) sel_bad++;
      nz_vec = seq[(load_cnt - 1 < seq_len) ? load_cnt - 1 : seq_len - 1];
    end
    if (done) done_cnt++;
  end

  task automatic clr_mon();
    load_cnt  = 0;
    done_cnt  = 0;
    first_sel = 0;
    sel_bad   = 0;
  endtask

  task automatic run(input string tag, input bit hold, output int lat);
    clr_mon();
    start = 1'b1;
    @(posedge clk);
    #1 if (!hold) start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 400);
    start = 1'b0;
    chk({tag, "_done_seen"}, int'(done), 1);
  endtask

  int lat;
  int n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    #23;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mem_load", int'(mem_load), 0);
    chk("rst_sel_init", int'(sel_init), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_iter", int'(iter_cnt), 0);
    #4 rst_n = 1'b1;
    @(negedge clk);

    // Already one-hot at init.
    seq[0] = 6'b000100; seq_len = 1;
    run("t1", 1'b0, lat);
    chk("t1_lat", lat, 5);
    chk("t1_loads", load_cnt, 1);
    chk("t1_init_sel", first_sel, 1);
    chk("t1_valid", int'(valid), 1);
    chk("t1_winner", int'(winner), 2);
    chk("t1_iter", int'(iter_cnt), 0);
    chk("t1_timeout", int'(timeout), 0);
    chk("t1_busy_in_done", int'(busy), 1);
    @(negedge clk);
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_valid_held", int'(valid), 1);
`ifdef MAXNET_CTRL_PERF_EN
    chk("t1_cyc", int'(cyc_cnt), 5);
    repeat (3) @(negedge clk);
    chk("t1_cyc_stable", int'(cyc_cnt), 5);
`endif

    // Three update commits before a single survivor.
    seq[0] = 6'b101101; seq[1] = 6'b101101; seq[2] = 6'b101101; seq[3] = 6'b100000; seq_len = 4;
    run("t2", 1'b0, lat);
    chk("t2_lat", lat, 17);
    chk("t2_loads", load_cnt, 4);
    chk("t2_upd_sel", sel_bad, 0);
    chk("t2_valid", int'(valid), 1);
    chk("t2_winner", int'(winner), 5);
    chk("t2_iter", int'(iter_cnt), 3);
    @(negedge clk);

    // Everything inhibited after one commit.
    seq[0] = 6'b000011; seq[1] = 6'b000000; seq_len = 2;
    run("t3", 1'b0, lat);
    chk("t3_loads", load_cnt, 2);
    chk("t3_valid", int'(valid), 0);
    chk("t3_timeout", int'(timeout), 0);
    chk("t3_winner", int'(winner), 0);
    chk("t3_iter", int'(iter_cnt), 1);
    @(negedge clk);

    // Stuck vector hits the iteration limit of 4.
    seq[0] = 6'b111111; seq_len = 1;
    run("t4", 1'b0, lat);
    chk("t4_lat", lat, 21);
    chk("t4_loads", load_cnt, 5);
    chk("t4_timeout", int'(timeout), 1);
    chk("t4_valid", int'(valid), 0);
    chk("t4_iter", int'(iter_cnt), 4);
    @(negedge clk);

    // Asynchronous reset in the middle of iteration 2.
    clr_mon();
    seq[0] = 6'b111111; seq_len = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (load_cnt < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_iter2", load_cnt, 3);
    chk("t5_iter_before", int'(iter_cnt), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_mem_load", int'(mem_load), 0);
    chk("t5_iter", int'(iter_cnt), 0);
    chk("t5_valid", int'(valid), 0);
    chk("t5_timeout", int'(timeout), 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_busy_after", int'(busy), 0);

    // Start held high across a run gives exactly one run.
    seq[0] = 6'b000100; seq_len = 1;
    run("t6", 1'b1, lat);
    chk("t6_lat", lat, 5);
    chk("t6_valid", int'(valid), 1);
    chk("t6_winner", int'(winner), 2);
    repeat (4) @(negedge clk);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_loads", load_cnt, 1);
    chk("t6_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/maxnet_ctrl.md
Name: maxnet_ctrl

Overview:
- Sequencing FSM for the MaxNet datapath: one 6-entry, 32-bit float register memory with a `load` strobe, plus the combinational/pipelined lateral-inhibition update logic.
- Loads the initial activations and repeatedly commits updated activations back into the memory.
- After every commit, checks the per-entry nonzero flags.
- Stops when exactly one activation remains nonzero, all are zero, or an iteration limit is hit.
- Reports the winner index and completion status.

Parameters:
- N, 6, number of activations (memory entries); must be >=2.
- UPD_LAT, 2, cycles the update datapath needs after a memory write before its outputs and `nz_vec` are valid; must be >=1.
- MAX_ITER, 64, update iterations allowed before timeout.
- IW, 7, width of the iteration counter; must satisfy 2^IW > MAX_ITER.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- nz_vec  in  N  per-entry flag from the datapath: activation is strictly positive (nonzero, sign clear).
- mem_load  out  1  drives the memory `load` input.
- sel_init  out  1  memory write-data mux select: 1 = external inputs, 0 = update datapath results.
- busy  out  1  high from the cycle after `start` is accepted until DONE is exited.
- done  out  1  one-cycle completion pulse.
- valid  out  1  exactly one winner found; held until the next accepted start.
- timeout  out  1  iteration limit reached; held until the next accepted start.
- winner  out  $clog2(N)  index of the surviving entry; held until the next accepted start.
- iter_cnt  out  IW  number of update commits in the current or last run.

Behaviour:
- Reset (asynchronous, active-low; takes effect immediately, including mid-run):
  - state = IDLE.
  - mem_load, sel_init, busy, done, valid, timeout = 0; winner = 0; iter_cnt = 0.
  - Reset does not clear the memory contents.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - start=1 → INIT; clears valid, timeout, winner and iter_cnt on that edge.
  - start is ignored in all other states.
- INIT, 1 cycle: mem_load=1, sel_init=1 → SETTLE.
- SETTLE, UPD_LAT cycles: mem_load=0, sel_init=0; settle counter counts 0..UPD_LAT-1 → CHECK.
- CHECK, 1 cycle: popcount(nz_vec) decides the next state.
  - ==1 → DONE; valid=1; winner = index of the set bit.
  - ==0 → DONE; valid=0 (all inhibited, e.g. tied maxima).
  - >=2 and iter_cnt==MAX_ITER → DONE; timeout=1; valid=0.
  - >=2 otherwise → LOAD.
- LOAD, 1 cycle: mem_load=1, sel_init=0, iter_cnt+=1 → SETTLE.
- DONE, 1 cycle: done=1, busy=1 → IDLE.
- Latency:
  - Run with K update commits: 1 + (K+1)·(UPD_LAT+1) + K + 1 cycles, measured from the first INIT cycle to the DONE cycle inclusive.
  - Initial inputs that are already one-hot (K=0) give done at cycle UPD_LAT+3 after start is sampled.
- iter_cnt saturates at MAX_ITER and never wraps.
- Unreachable state encodings return to IDLE.

Optional Feature:
- Macro: MAXNET_CTRL_PERF_EN.
- When defined:
  - Adds output cyc_cnt [15:0], which counts clock cycles while busy=1.
  - Cleared on an accepted start, saturates at 16'hFFFF, held after DONE.
  - Reset value 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package maxnet_pkg holds:
  - the state enum (IDLE, INIT, SETTLE, CHECK, LOAD, DONE);
  - the default N, UPD_LAT and MAX_ITER constants;
  - the index-width function.
- One sub-module, maxnet_onehot_enc: combinational; takes nz_vec and returns `zero`, `one`, `many` and the index of the lowest set bit.

Test Plan:
- UPD_LAT=2; start pulse; nz_vec=6'b000100 constant → one mem_load with sel_init=1; done at cycle 5 after start; valid=1, winner=2, iter_cnt=0.
- nz_vec=6'b101101 for 3 CHECKs, then 6'b100000 → 4 mem_load pulses total (1 init + 3 update); valid=1, winner=5, iter_cnt=3.
- nz_vec goes 6'b000011 → 6'b000000 → done with valid=0, timeout=0, iter_cnt=1.
- MAX_ITER=4; nz_vec stuck at 6'b111111 → 5 mem_load pulses; timeout=1, valid=0, iter_cnt=4.
- Assert rst_n=0 during SETTLE of iteration 2 → outputs clear immediately; busy=0; a subsequent start runs normally. Also: start held high during a run is ignored, and exactly one run occurs per IDLE acceptance.
- With MAXNET_CTRL_PERF_EN defined, the first scenario → cyc_cnt=5 after done and stable thereafter.
